btn_step_ctrl: RTL and testbench

BTN_STEP_CTRL -- requirements
Module: btn_step_ctrl

---
 rtl/btn_step_pkg.sv | 19 +
 rtl/btn_step_ctrl_if.sv | 11 +
 rtl/btn_debounce.sv | 42 ++++
 rtl/btn_step_ctrl.sv | 105 ++++++++++
 tb/tb_btn_step_ctrl.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/btn_step_pkg.sv
// Shared types and default timing for the button-driven single-step controller.
package btn_step_pkg;

    typedef enum logic [1:0] {
        st_idle = 2'd0,
        st_high = 2'd1,
        st_gap  = 2'd2
    } step_state_t;

    localparam int DEF_DEBOUNCE_CYC  = 100000;
    localparam int DEF_STEP_HIGH_CYC = 250000;
    localparam int DEF_STEP_LOW_CYC  = 250000;
    localparam int DEF_RESET_CONT    = 1;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/btn_step_ctrl_if.sv
// Button inputs and clock-control outputs of the step controller.
interface btn_step_ctrl_if;
    logic        btn_mode;
    logic        btn_step;
    logic        cont;
    logic        step;
    logic [15:0] step_cnt;

    modport master (output btn_mode, btn_step, input cont, step, step_cnt);
    modport slave  (input btn_mode, btn_step, output cont, step, step_cnt);
endinterface

// File: rtl/btn_debounce.sv
// 2-FF synchronizer, stability-count debouncer and press (rising-edge) detect.
module btn_debounce
    import btn_step_pkg::*;
#(
    parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC
) (
    input  logic clk5m,
    input  logic rst,
    input  logic btn,
    output logic rise
);
    localparam int CW = $clog2(DEBOUNCE_CYC + 1);

    logic          s1, s2, lvl, lvl_d;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk5m or posedge rst) begin
        if (rst) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            lvl   <= 1'b0;
            lvl_d <= 1'b0;
            cnt   <= '0;
        end else begin
            s1    <= btn;
            s2    <= s1;
            lvl_d <= lvl;
            // any return to the accepted level restarts the stability count
            if (s2 == lvl) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYC - 1)) begin
                lvl <= s2;
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    assign rise = lvl & ~lvl_d;

endmodule

// File: rtl/btn_step_ctrl.sv
// Run/single-step clock control from two debounced push buttons.
//   state   | meaning
//   st_idle | waiting; mode toggles apply at once, step press starts a pulse
//   st_high | step output high for STEP_HIGH_CYC cycles
//   st_gap  | step low for STEP_LOW_CYC cycles before another press is taken
module btn_step_ctrl
    import btn_step_pkg::*;
#(
    parameter int DEBOUNCE_CYC  = DEF_DEBOUNCE_CYC,
    parameter int STEP_HIGH_CYC = DEF_STEP_HIGH_CYC,
    parameter int STEP_LOW_CYC  = DEF_STEP_LOW_CYC,
    parameter int RESET_CONT    = DEF_RESET_CONT
) (
    input logic            clk5m,
    input logic            rst,
    btn_step_ctrl_if.slave bus
);
    localparam int TW = $clog2(max_int(STEP_HIGH_CYC, STEP_LOW_CYC) + 1);

    logic mode_evt, step_evt;

    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_mode (
        .clk5m (clk5m),
        .rst   (rst),
        .btn   (bus.btn_mode),
        .rise  (mode_evt)
    );

    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_step (
        .clk5m (clk5m),
        .rst   (rst),
        .btn   (bus.btn_step),
        .rise  (step_evt)
    );

    step_state_t   state, state_nx;
    logic [TW-1:0] tmr, tmr_nx;
    logic          cont_q, cont_nx;
    logic          pend, pend_nx;
    logic [15:0]   cnt_q, cnt_nx;
    logic          step_q;

    always_ff @(posedge clk5m or posedge rst) begin
        if (rst) begin
            state  <= st_idle;
            tmr    <= '0;
            cont_q <= (RESET_CONT != 0);
            pend   <= 1'b0;
            cnt_q  <= '0;
            step_q <= 1'b0;
        end else begin
            state  <= state_nx;
            tmr    <= tmr_nx;
            cont_q <= cont_nx;
            pend   <= pend_nx;
            cnt_q  <= cnt_nx;
            step_q <= (state_nx == st_high);
        end
    end

    always_comb begin
        state_nx = state;
        tmr_nx   = tmr;
        cont_nx  = cont_q;
        pend_nx  = pend;
        cnt_nx   = cnt_q;
        unique case (state)
            st_idle: begin
                if (mode_evt) begin
                    cont_nx = ~cont_q;
                end else if (step_evt && !cont_q) begin
                    state_nx = st_high;
                    tmr_nx   = TW'(STEP_HIGH_CYC - 1);
                    cnt_nx   = cnt_q + 16'd1;
                end
            end
            st_high: begin
                pend_nx = pend ^ mode_evt;
                if (tmr == '0) begin
                    state_nx = st_gap;
                    tmr_nx   = TW'(STEP_LOW_CYC - 1);
                end else begin
                    tmr_nx = tmr - TW'(1);
                end
            end
            st_gap: begin
                pend_nx = pend ^ mode_evt;
                // deferred mode change lands only once the pulse is fully done
                if (tmr == '0) begin
                    state_nx = st_idle;
                    cont_nx  = cont_q ^ pend_nx;
                    pend_nx  = 1'b0;
                end else begin
                    tmr_nx = tmr - TW'(1);
                end
            end
            default: state_nx = st_idle;
        endcase
    end

    assign bus.cont     = cont_q;
    assign bus.step     = step_q;
    assign bus.step_cnt = cnt_q;

endmodule

// File: tb/tb_btn_step_ctrl.sv
// Self-checking bench for btn_step_ctrl: directed scenarios plus random button traffic.
module tb_btn_step_ctrl;
    localparam int D  = 4;
    localparam int H  = 3;
    localparam int L  = 2;
    localparam int RC = 0;

    logic clk5m = 1'b0;
    logic rst   = 1'b1;

    btn_step_ctrl_if bus ();

    btn_step_ctrl #(
        .DEBOUNCE_CYC  (D),
        .STEP_HIGH_CYC (H),
        .STEP_LOW_CYC  (L),
        .RESET_CONT    (RC)
    ) dut (
        .clk5m (clk5m),
        .rst   (rst),
        .bus   (bus)
    );

    always #100 clk5m = ~clk5m;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: index 0 = mode button, 1 = step button.
    // A button is accepted after D consecutive synced samples differ from the
    // accepted level; a press is seen by the controller one edge later. A pulse
    // started at edge k is high after edges k..k+H-1 and the controller is busy
    // until edge k+H+L.
    bit        m_dly [2][2];
    int        m_run [2];
    bit        m_lvl [2];
    bit        m_rise[2];
    bit        m_cont, m_pend, m_step, m_active;
    bit [15:0] m_cnt;
    int        m_k, m_start;

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            m_dly[i][0] = 0; m_dly[i][1] = 0;
            m_run[i] = 0; m_lvl[i] = 0; m_rise[i] = 0;
        end
        m_cont = (RC != 0); m_pend = 0; m_step = 0; m_active = 0;
        m_cnt = 0; m_k = 0; m_start = 0;
    endfunction

    function automatic void model_edge(input bit raw_m, input bit raw_s);
        bit evt[2];
        bit raw[2];
        bit sy;
        bit idle;
        raw = '{raw_m, raw_s};
        m_k++;
        for (int i = 0; i < 2; i++) begin
            evt[i]    = m_rise[i];
            m_rise[i] = 0;
            sy          = m_dly[i][1];
            m_dly[i][1] = m_dly[i][0];
            m_dly[i][0] = raw[i];
            if (sy == m_lvl[i]) m_run[i] = 0;
            else begin
                m_run[i]++;
                if (m_run[i] == D) begin
                    m_lvl[i] = sy; m_run[i] = 0; m_rise[i] = sy;
                end
            end
        end
        idle = !m_active || (m_k > m_start + H + L);
        if (idle) begin
            m_active = 0;
            if (evt[0]) m_cont = !m_cont;
            else if (evt[1] && !m_cont) begin
                m_active = 1; m_start = m_k; m_cnt = m_cnt + 16'd1;
            end
        end else begin
            if (evt[0]) m_pend = !m_pend;
            if (m_k == m_start + H + L) begin
                m_cont = m_cont ^ m_pend; m_pend = 0;
            end
        end
        m_step = m_active && (m_k >= m_start) && (m_k < m_start + H);
    endfunction

    task automatic tick();
        @(posedge clk5m);
        model_edge(bus.btn_mode, bus.btn_step);
        @(negedge clk5m);
        chk("step", 32'(bus.step), 32'(m_step));
        chk("cont", 32'(bus.cont), 32'(m_cont));
        chk("step_cnt", 32'(bus.step_cnt), 32'(m_cnt));
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Ticks until step rises (bounded); returns edge count, 0 if it never came.
    task automatic wait_step(input int budget, output int lat);
        lat = 0;
        for (int i = 1; i <= budget; i++) begin
            tick();
            if (bus.step === 1'b1) begin lat = i; break; end
        end
    endtask

    task automatic count_high(output int w);
        w = 1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.step === 1'b1) w++;
            else break;
        end
    endtask

    initial begin
        int lat, w, pulses;
        bit prev;
        int hold[2];

        bus.btn_mode = 1'b0;
        bus.btn_step = 1'b0;
        model_reset();
        repeat (3) @(negedge clk5m);
        chk("rst_step", 32'(bus.step), 32'd0);
        chk("rst_cont", 32'(bus.cont), 32'(RC));
        chk("rst_cnt", 32'(bus.step_cnt), 32'd0);
        rst = 1'b0;
        ticks(3);

        // clean press: latency D+3, width H
        bus.btn_step = 1'b1;
        wait_step(20, lat);
        chk("press_latency", lat, D + 3);
        count_high(w);
        chk("pulse_width", w, H);
        ticks(20 - lat - w);
        chk("cnt_after_first", 32'(bus.step_cnt), 32'd1);
        bus.btn_step = 1'b0;
        ticks(12);

        // bouncing press then stable hold: one pulse only
        pulses = 0; prev = 0;
        for (int s = 0; s < 8; s++) begin
            bus.btn_step = (s % 2 == 0);
            for (int c = 0; c < 2; c++) begin
                tick();
                if (bus.step && !prev) pulses++;
                prev = bus.step;
            end
        end
        chk("bounce_no_pulse", pulses, 0);
        bus.btn_step = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (bus.step && !prev) pulses++;
            prev = bus.step;
        end
        chk("bounce_one_pulse", pulses, 1);
        bus.btn_step = 1'b0;
        ticks(12);

        // mode press whose event lands in HIGH: toggle deferred to IDLE
        bus.btn_step = 1'b1;
        ticks(2);
        bus.btn_mode = 1'b1;
        wait_step(20, lat);
        count_high(w);
        chk("pend_width", w, H);
        ticks(8);
        chk("pend_cont_applied", 32'(bus.cont), 32'd1);
        bus.btn_step = 1'b0;
        bus.btn_mode = 1'b0;
        ticks(12);
        // run mode discards step presses
        bus.btn_step = 1'b1;
        ticks(14);
        chk("run_discard_cnt", 32'(bus.step_cnt), 32'd3);
        bus.btn_step = 1'b0;
        bus.btn_mode = 1'b1;
        ticks(12);
        bus.btn_mode = 1'b0;
        ticks(12);
        chk("back_to_step_mode", 32'(bus.cont), 32'd0);

        // counter wrap
        force dut.cnt_q = 16'hffff;
        #1;
        release dut.cnt_q;
        m_cnt = 16'hffff;
        chk("cnt_preset", 32'(bus.step_cnt), 32'hffff);
        bus.btn_step = 1'b1;
        wait_step(20, lat);
        chk("cnt_wrap", 32'(bus.step_cnt), 32'd0);
        ticks(8);
        bus.btn_step = 1'b0;
        ticks(12);

        // async reset mid-pulse with button held through release
        bus.btn_step = 1'b1;
        wait_step(20, lat);
        chk("pre_rst_step", 32'(bus.step), 32'd1);
        #10 rst = 1'b1;
        #1;
        chk("rst_async_step", 32'(bus.step), 32'd0);
        chk("rst_async_cont", 32'(bus.cont), 32'(RC));
        chk("rst_async_cnt", 32'(bus.step_cnt), 32'd0);
        model_reset();
        repeat (2) @(negedge clk5m);
        rst = 1'b0;
        wait_step(20, lat);
        chk("held_through_rst_latency", lat, D + 3);
        chk("held_through_rst_cnt", 32'(bus.step_cnt), 32'd1);
        ticks(8);
        bus.btn_step = 1'b0;
        ticks(12);

        // random bouncy traffic on both buttons
        hold[0] = 1; hold[1] = 1;
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < 2; i++) begin
                hold[i]--;
                if (hold[i] == 0) begin
                    if (i == 0) bus.btn_mode = ~bus.btn_mode;
                    else        bus.btn_step = ~bus.btn_step;
                    hold[i] = (i == 0) ? int'($urandom_range(1, 40)) : int'($urandom_range(1, 12));
                end
            end
            tick();
        end
        bus.btn_mode = 1'b0;
        bus.btn_step = 1'b0;
        ticks(15);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
